i2c_init_seq: RTL and testbench

Parametrised I2C register-initialisation sequencer for peripherals such as the ADV7513 HDMI transmitter and audio codecs. It steps through an external table of write, verify, delay and end entries, driving an I2C master core through its start/end/ack handshake. Compared with the existing fixed-table configurator it adds bounded retries with an error report, read-back verification, timed waits, and re-run on request when configuration inputs change. It sits between the board-level config logic and the shared `i2c` master core.

---
 rtl/i2c_init_pkg.sv | 33 +++
 rtl/i2c_init_seq_if.sv | 24 ++
 rtl/i2c_init_tick.sv | 51 +++++
 rtl/i2c_init_seq.sv | 143 ++++++++++++++
 tb/tb_i2c_init_seq.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_init_pkg.sv
// Shared types for the I2C register-initialisation sequencer: table entry layout,
// opcodes and FSM states.
package i2c_init_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_WAIT   = 2'b01,
        OP_VERIFY = 2'b10,
        OP_END    = 2'b11
    } op_e;

    localparam int unsigned ENTRY_W = 18;

    // Entry layout: {op[1:0], sub[7:0], data[7:0]}
    localparam int unsigned OP_HI   = 17;
    localparam int unsigned OP_LO   = 16;
    localparam int unsigned SUB_HI  = 15;
    localparam int unsigned SUB_LO  = 8;
    localparam int unsigned DATA_HI = 7;
    localparam int unsigned DATA_LO = 0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StReq,
        StBusy,
        StXfer,
        StDelay,
        StDone,
        StFail
    } state_e;

endpackage

// File: rtl/i2c_init_seq_if.sv
// Request/response handshake between the init sequencer (master) and the shared
// i2c core (slave).
interface i2c_init_seq_if;

    logic       i2c_start;
    logic       i2c_read;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_wdata1;
    logic [7:0] i2c_wdata2;
    logic       i2c_end;
    logic       i2c_ack;
    logic [7:0] i2c_rdata;

    modport master (
        output i2c_start, i2c_read, i2c_addr, i2c_wdata1, i2c_wdata2,
        input  i2c_end, i2c_ack, i2c_rdata
    );

    modport slave (
        input  i2c_start, i2c_read, i2c_addr, i2c_wdata1, i2c_wdata2,
        output i2c_end, i2c_ack, i2c_rdata
    );

endinterface

// File: rtl/i2c_init_tick.sv
// Wait timer: a prescaler of CLK_HZ/1e6*WAIT_US cycles per unit feeding a unit
// down-counter. 'expired' rises so that residence after 'load' is units*unit cycles.
module i2c_init_tick #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned WAIT_US = 1000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       load,
    input  logic [7:0] units,
    output logic       expired
);

    localparam int unsigned UnitRaw = (CLK_HZ / 1_000_000) * WAIT_US;
    localparam int unsigned UnitCyc = (UnitRaw > 0) ? UnitRaw : 1;
    localparam int unsigned PreW    = (UnitCyc > 1) ? $clog2(UnitCyc) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(UnitCyc - 1);

    logic [PreW-1:0] pre_q, pre_d;
    logic [7:0]      cnt_q, cnt_d;

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        if (load) begin
            pre_d = '0;
            cnt_d = units;
        end else if (cnt_q != 8'd0) begin
            if (pre_q == PreLast) begin
                pre_d = '0;
                cnt_d = cnt_q - 8'd1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    // Look ahead by one cycle so the owner's state change lands on the final unit edge.
    assign expired = (cnt_q == 8'd0) || ((cnt_q == 8'd1) && (pre_q == PreLast));

endmodule

// File: rtl/i2c_init_seq.sv
// Table-driven I2C register initialiser: write/verify/wait/end entries with bounded
// retries, error reporting and re-run on restart from DONE or FAIL.
module i2c_init_seq
    import i2c_init_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned WAIT_US   = 1000,
    parameter int unsigned IDX_W     = 8,
    parameter int unsigned MAX_RETRY = 3,
    parameter logic [6:0]  DEV_ADDR  = 7'h39
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               restart,
    output logic [IDX_W-1:0]   tbl_idx,
    input  logic [ENTRY_W-1:0] tbl_data,
    i2c_init_seq_if.master     i2c,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [IDX_W-1:0]   err_idx
);

    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic [RetryW-1:0]  retry_q, retry_d;
    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic               start_q, start_d;
    op_e                fetch_op, cur_op;
    logic               xfer_ok, tick_load, tick_expired;

    assign fetch_op  = op_e'(tbl_data[OP_HI:OP_LO]);
    assign cur_op    = op_e'(entry_q[OP_HI:OP_LO]);
    assign xfer_ok   = !i2c.i2c_ack &&
                       ((cur_op != OP_VERIFY) || (i2c.i2c_rdata == entry_q[DATA_HI:DATA_LO]));
    assign tick_load = (state_q == StFetch) && (fetch_op == OP_WAIT);

    i2c_init_tick #(
        .CLK_HZ  (CLK_HZ),
        .WAIT_US (WAIT_US)
    ) u_tick (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .load    (tick_load),
        .units   (tbl_data[DATA_HI:DATA_LO]),
        .expired (tick_expired)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        retry_d   = retry_q;
        entry_d   = entry_q;
        start_d   = start_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                entry_d = tbl_data;
                unique case (fetch_op)
                    OP_WRITE, OP_VERIFY: begin
                        state_d = StReq;
                        start_d = 1'b1;
                    end
                    OP_WAIT: state_d = StDelay;
                    OP_END:  state_d = StDone;
                endcase
            end
            StReq:   state_d = StBusy;
            StBusy: begin
                if (!i2c.i2c_end) begin
                    state_d = StXfer;
                    start_d = 1'b0;
                end
            end
            StXfer: begin
                if (i2c.i2c_end) begin
                    if (xfer_ok) begin
                        idx_d   = idx_q + 1'b1;
                        retry_d = '0;
                        state_d = StFetch;
                    end else if (retry_q < RetryW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        start_d = 1'b1;
                        state_d = StReq;
                    end else begin
                        err_idx_d = idx_q;
                        state_d   = StFail;
                    end
                end
            end
            StDelay: begin
                if (tick_expired) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StFetch;
                end
            end
            StDone, StFail: begin
                if (restart) begin
                    idx_d     = '0;
                    err_idx_d = '0;
                    retry_d   = '0;
                    state_d   = StFetch;
                end
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            err_idx_q <= '0;
            retry_q   <= '0;
            entry_q   <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            retry_q   <= retry_d;
            entry_q   <= entry_d;
            start_q   <= start_d;
        end
    end

    // Request fields come from the latched entry, so they stay put for the whole transfer.
    assign i2c.i2c_start  = start_q;
    assign i2c.i2c_read   = (cur_op == OP_VERIFY);
    assign i2c.i2c_addr   = DEV_ADDR;
    assign i2c.i2c_wdata1 = entry_q[SUB_HI:SUB_LO];
    assign i2c.i2c_wdata2 = entry_q[DATA_HI:DATA_LO];

    assign tbl_idx = idx_q;
    assign err_idx = err_idx_q;
    assign busy    = (state_q != StIdle) && (state_q != StDone) && (state_q != StFail);
    assign done    = (state_q == StDone);
    assign error   = (state_q == StFail);

endmodule

// File: tb/tb_i2c_init_seq.sv
// Scoreboarded bench: stimulus queues expected transfers and slave responses, a monitor
// checks each i2c_start request; a second instance covers the no-retry verify failure.
module tb_i2c_init_seq;
    import i2c_init_pkg::*;

    localparam int unsigned IDX_W = 8;

    typedef struct {
        int         idx;
        logic       rd;
        logic [7:0] wd1;
        logic [7:0] wd2;
        int         gap;   // cycles from previous end rise to this start; -1 = unchecked
    } xfer_t;

    typedef struct {
        logic       nack;
        logic [7:0] rdata;
    } resp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xfer_t exp_q[$];
    resp_t rsp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    time   last_end_t = 0;
    int    starts1 = 0;

    logic [ENTRY_W-1:0] tbl0 [0:255];
    logic [ENTRY_W-1:0] tbl1 [0:255];
    logic               restart0 = 1'b0;
    logic [IDX_W-1:0]   idx0, err_idx0, idx1, err_idx1;
    logic               busy0, done0, error0, busy1, done1, error1;

    i2c_init_seq_if bus0 ();
    i2c_init_seq_if bus1 ();

    i2c_init_seq #(
        .CLK_HZ(1_000_000), .WAIT_US(10), .IDX_W(IDX_W), .MAX_RETRY(3), .DEV_ADDR(7'h39)
    ) dut0 (
        .iCLK(clk), .iRST_N(rst_n), .restart(restart0), .tbl_idx(idx0),
        .tbl_data(tbl0[idx0]), .i2c(bus0), .busy(busy0), .done(done0), .error(error0),
        .err_idx(err_idx0)
    );

    i2c_init_seq #(
        .CLK_HZ(1_000_000), .WAIT_US(10), .IDX_W(IDX_W), .MAX_RETRY(0), .DEV_ADDR(7'h39)
    ) dut1 (
        .iCLK(clk), .iRST_N(rst_n), .restart(1'b0), .tbl_idx(idx1),
        .tbl_data(tbl1[idx1]), .i2c(bus1), .busy(busy1), .done(done1), .error(error1),
        .err_idx(err_idx1)
    );

    function automatic logic [ENTRY_W-1:0] ent(input op_e op, input logic [7:0] sub,
                                               input logic [7:0] data);
        return {op, sub, data};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo,
                           input longint hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic push_x(input int idx, input logic rd, input logic [7:0] wd1,
                          input logic [7:0] wd2, input int gap);
        xfer_t x;
        x.idx = idx; x.rd = rd; x.wd1 = wd1; x.wd2 = wd2; x.gap = gap;
        exp_q.push_back(x);
    endtask

    task automatic push_r(input logic nack, input logic [7:0] rdata);
        resp_t r;
        r.nack = nack; r.rdata = rdata;
        rsp_q.push_back(r);
    endtask

    task automatic pulse_restart();
        restart0 = 1'b1;
        @(negedge clk);
        restart0 = 1'b0;
    endtask

    task automatic wait_end0(input string name);
        int i = 0;
        while (!(done0 || error0) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk({name, " finished within budget"}, longint'(done0 || error0), 1);
    endtask

    // Slave model for dut0: 3 busy cycles per transfer, response taken from rsp_q.
    initial begin
        int    cnt = 0;
        resp_t r;
        bus0.i2c_end   <= 1'b1;
        bus0.i2c_ack   <= 1'b0;
        bus0.i2c_rdata <= 8'h00;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                bus0.i2c_end <= 1'b1;
                cnt = 0;
            end else if (bus0.i2c_end) begin
                if (bus0.i2c_start) begin
                    bus0.i2c_end <= 1'b0;
                    cnt = 3;
                end
            end else if (cnt != 0) begin
                cnt--;
            end else begin
                if (rsp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL slave0 response: no queued response, required one queued");
                    r.nack = 1'b1;
                    r.rdata = 8'h00;
                end else begin
                    r = rsp_q.pop_front();
                end
                bus0.i2c_ack   <= r.nack;
                bus0.i2c_rdata <= r.rdata;
                bus0.i2c_end   <= 1'b1;
                last_end_t = $time;
            end
        end
    end

    // Slave model for dut1: always ACKs, reads return 0x60.
    initial begin
        int cnt = 0;
        bus1.i2c_end   <= 1'b1;
        bus1.i2c_ack   <= 1'b0;
        bus1.i2c_rdata <= 8'h60;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                bus1.i2c_end <= 1'b1;
                cnt = 0;
            end else if (bus1.i2c_end) begin
                if (bus1.i2c_start) begin
                    starts1++;
                    if (starts1 == 2)
                        chk("dut1 verify request", {bus1.i2c_read, bus1.i2c_wdata1,
                            bus1.i2c_wdata2}, {1'b1, 8'h17, 8'h62});
                    bus1.i2c_end <= 1'b0;
                    cnt = 3;
                end
            end else if (cnt != 0) begin
                cnt--;
            end else begin
                bus1.i2c_end <= 1'b1;
            end
        end
    end

    // Monitor: every new request on dut0 is popped against the scoreboard.
    initial begin
        logic  prev = 1'b0;
        xfer_t e;
        forever begin
            @(negedge clk);
            if (bus0.i2c_start && !prev) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL xfer unexpected: got request idx %0d, required none", idx0);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer tbl_idx", idx0, e.idx);
                    chk("xfer read", bus0.i2c_read, e.rd);
                    chk("xfer wdata1", bus0.i2c_wdata1, e.wd1);
                    chk("xfer wdata2", bus0.i2c_wdata2, e.wd2);
                    chk("xfer addr", bus0.i2c_addr, 7'h39);
                    if (e.gap >= 0)
                        chk_rng("xfer gap cycles", ($time - 5 - last_end_t) / 10,
                                e.gap - 1, e.gap + 1);
                end
            end
            prev = bus0.i2c_start;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            tbl0[i] = ent(OP_END, 8'h00, 8'h00);
            tbl1[i] = ent(OP_END, 8'h00, 8'h00);
        end
        tbl0[0] = ent(OP_WRITE, 8'h98, 8'h03);
        tbl0[1] = ent(OP_WRITE, 8'h41, 8'h10);
        tbl1[0] = ent(OP_WRITE, 8'h98, 8'h03);
        tbl1[1] = ent(OP_VERIFY, 8'h17, 8'h62);

        repeat (3) @(negedge clk);
        chk("reset tbl_idx", idx0, 0);
        chk("reset i2c_start", bus0.i2c_start, 0);
        chk("reset i2c_read", bus0.i2c_read, 0);
        chk("reset wdata", {bus0.i2c_wdata1, bus0.i2c_wdata2}, 0);
        chk("reset i2c_addr", bus0.i2c_addr, 7'h39);
        chk("reset status", {busy0, done0, error0}, 0);
        chk("reset err_idx", err_idx0, 0);

        // Plain write run; second request follows end rise by FETCH + REQ.
        push_x(0, 1'b0, 8'h98, 8'h03, -1);
        push_x(1, 1'b0, 8'h41, 8'h10, 2);
        push_r(1'b0, 8'h00);
        push_r(1'b0, 8'h00);
        rst_n = 1'b1;
        wait_end0("write run");
        chk("write done", done0, 1);
        chk("write error", error0, 0);
        chk("write tbl_idx", idx0, 2);
        chk("write busy", busy0, 0);
        chk("write all xfers seen", exp_q.size(), 0);

        repeat (20) @(negedge clk);
        chk("verify-mismatch error", error1, 1);
        chk("verify-mismatch err_idx", err_idx1, 1);
        chk("verify-mismatch done/busy", {done1, busy1}, 0);
        chk("verify-mismatch attempts", starts1, 2);

        // NACK twice then ACK on index 1; a restart pulse while busy must be ignored.
        push_x(0, 1'b0, 8'h98, 8'h03, -1);
        push_r(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) push_x(1, 1'b0, 8'h41, 8'h10, -1);
        push_r(1'b1, 8'h00);
        push_r(1'b1, 8'h00);
        push_r(1'b0, 8'h00);
        pulse_restart();
        chk("restart from done busy", busy0, 1);
        repeat (4) @(negedge clk);
        pulse_restart();
        wait_end0("nack retry");
        chk("retry done", done0, 1);
        chk("retry error", error0, 0);
        chk("retry tbl_idx", idx0, 2);
        chk("retry xfers consumed", exp_q.size(), 0);

        // Four NACKs on index 1 exhaust MAX_RETRY=3.
        push_x(0, 1'b0, 8'h98, 8'h03, -1);
        push_r(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            push_x(1, 1'b0, 8'h41, 8'h10, -1);
            push_r(1'b1, 8'h00);
        end
        pulse_restart();
        wait_end0("retry exhaustion");
        chk("exhaust error", error0, 1);
        chk("exhaust err_idx", err_idx0, 1);
        chk("exhaust done/busy", {done0, busy0}, 0);
        chk("exhaust attempts", exp_q.size(), 0);

        // Verify pass, restarted from FAIL.
        tbl0[0] = ent(OP_VERIFY, 8'h17, 8'h62);
        tbl0[1] = ent(OP_END, 8'h00, 8'h00);
        push_x(0, 1'b1, 8'h17, 8'h62, -1);
        push_r(1'b0, 8'h62);
        pulse_restart();
        chk("restart clears error", {error0, err_idx0}, 0);
        wait_end0("verify pass");
        chk("verify done", done0, 1);
        chk("verify tbl_idx", idx0, 1);

        // WAIT 5 units of 10 us at 1 MHz: 50 cycles plus XFER->FETCH, DELAY->FETCH, ->REQ.
        tbl0[0] = ent(OP_WRITE, 8'h98, 8'h03);
        tbl0[1] = ent(OP_WAIT, 8'h00, 8'h05);
        tbl0[2] = ent(OP_WRITE, 8'h41, 8'h10);
        tbl0[3] = ent(OP_END, 8'h00, 8'h00);
        push_x(0, 1'b0, 8'h98, 8'h03, -1);
        push_x(2, 1'b0, 8'h41, 8'h10, 53);
        push_r(1'b0, 8'h00);
        push_r(1'b0, 8'h00);
        pulse_restart();
        wait_end0("wait entry");
        chk("wait done", done0, 1);
        chk("wait tbl_idx", idx0, 3);

        // Reset in the middle of a transfer.
        tbl0[1] = ent(OP_WRITE, 8'h41, 8'h10);
        tbl0[2] = ent(OP_END, 8'h00, 8'h00);
        push_x(0, 1'b0, 8'h98, 8'h03, -1);
        push_r(1'b0, 8'h00);
        pulse_restart();
        begin
            int i = 0;
            while (bus0.i2c_end && i < 50) begin
                @(negedge clk);
                i++;
            end
        end
        chk("mid-transfer reached", bus0.i2c_end, 0);
        rst_n = 1'b0;
        #1;
        chk("mid-reset i2c_start", bus0.i2c_start, 0);
        chk("mid-reset tbl_idx", idx0, 0);
        chk("mid-reset status", {busy0, done0, error0}, 0);
        exp_q.delete();
        rsp_q.delete();
        @(negedge clk);
        push_x(0, 1'b0, 8'h98, 8'h03, -1);
        push_x(1, 1'b0, 8'h41, 8'h10, 2);
        push_r(1'b0, 8'h00);
        push_r(1'b0, 8'h00);
        rst_n = 1'b1;
        wait_end0("rerun after reset");
        chk("rerun done", done0, 1);
        chk("rerun tbl_idx", idx0, 2);
        chk("rerun xfers consumed", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
